// File: rtl/pool_engine_axis_if.sv
// Bus bundles for pool_engine_axis: an AXI-Stream bundle (used for both the
// input and output stream) and an APB bundle for the register file.
interface pool_engine_axis_if #(
  parameter int DATA_W = 32
) ();
  logic                  TREADY;
  logic [DATA_W-1:0]     TDATA;
  logic [DATA_W/8-1:0]   TKEEP;
  logic                  TUSER;
  logic                  TLAST;
  logic                  TVALID;

  modport master (input TREADY, output TDATA, TKEEP, TUSER, TLAST, TVALID);
  modport slave  (output TREADY, input TDATA, TKEEP, TUSER, TLAST, TVALID);
endinterface

interface pool_engine_apb_if ();
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/pool_engine_axis.sv
// pool_engine_axis: streaming 2x2 / stride-2 signed max-pool engine.
// Input beats arrive in (row y, column x, channel group g) order, LANES
// signed elements per beat. A single line buffer holds partial maxima for
// one output row; the y-odd/x-odd beat completes a window and emits it.
// APB register file: CTRL (start), STATUS, FLEN, NUM_CH, CLK_COUNT.
// Optional feature: define POOL_RELU_EN to clamp negative output lanes to 0
// (STATUS bit4 then reads 1).
module pool_engine_axis #(
  parameter int DATA_W   = 32,
  parameter int ELEM_W   = 8,
  parameter int MAX_FLEN = 64,
  parameter int MAX_CH   = 256
) (
  input  logic               CLK,
  input  logic               RESETN,
  pool_engine_axis_if.slave  S_AXIS,
  pool_engine_axis_if.master M_AXIS,
  pool_engine_apb_if.slave   APB
);

  localparam int LANES = DATA_W / ELEM_W;
  localparam int G_MAX = MAX_CH / LANES;
  localparam int DEPTH = (MAX_FLEN / 2) * G_MAX;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [6:0] MAX_FLEN_V = 7'(MAX_FLEN);
  localparam logic [8:0] MAX_CH_V   = 9'(MAX_CH);
  localparam logic [8:0] LANES_V    = 9'(LANES);

`ifdef POOL_RELU_EN
  localparam logic RELU_ON = 1'b1;

  function automatic logic [DATA_W-1:0] apply_relu(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = v;
    for (int i = 0; i < LANES; i++) begin
      if (v[i*ELEM_W + ELEM_W - 1]) r[i*ELEM_W +: ELEM_W] = '0;
    end
    return r;
  endfunction
`else
  localparam logic RELU_ON = 1'b0;

  function automatic logic [DATA_W-1:0] apply_relu(input logic [DATA_W-1:0] v);
    return v;
  endfunction
`endif

  function automatic logic [DATA_W-1:0] lane_max(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if ($signed(a[i*ELEM_W +: ELEM_W]) > $signed(b[i*ELEM_W +: ELEM_W]))
        r[i*ELEM_W +: ELEM_W] = a[i*ELEM_W +: ELEM_W];
      else
        r[i*ELEM_W +: ELEM_W] = b[i*ELEM_W +: ELEM_W];
    end
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [6:0]        flen_reg, act_flen;
  logic [8:0]        num_ch_reg, act_g;
  logic [6:0]        x_cnt, y_cnt;
  logic [8:0]        g_cnt;
  logic              done_q, cfg_err_q, tlast_err_q;
  logic [31:0]       clk_count;
  logic              s_tready, busy;
  logic              m_valid_q, m_last_q;
  logic [DATA_W-1:0] m_data_q;
  logic [DATA_W-1:0] line_buf [DEPTH];

  logic              apb_wr, start_req, start_window, cfg_ok, start_ok, start_bad;
  logic              s_hs, m_hs, x_last, y_last, g_last, last_in;
  logic [15:0]       paddr_lo, idx_full;
  logic [IDX_W-1:0]  buf_idx;
  logic [DATA_W-1:0] buf_rd, win_max, buf_wdata;
  logic              buf_we, emit;

  assign paddr_lo     = APB.PADDR[15:0];
  assign apb_wr       = APB.PSEL && APB.PENABLE && APB.PWRITE;
  assign start_req    = apb_wr && (paddr_lo == 16'h0000) && APB.PWDATA[0];
  assign start_window = (state_q == IDLE) || (state_q == DONE);
  assign cfg_ok       = (flen_reg != 7'd0) && !flen_reg[0] && (flen_reg <= MAX_FLEN_V) &&
                        (num_ch_reg != 9'd0) && (num_ch_reg <= MAX_CH_V) &&
                        ((num_ch_reg % LANES_V) == 9'd0);
  assign start_ok     = start_req && start_window && cfg_ok;
  assign start_bad    = start_req && start_window && !cfg_ok;

  assign s_hs    = S_AXIS.TVALID && s_tready;
  assign m_hs    = m_valid_q && M_AXIS.TREADY;
  assign x_last  = (x_cnt == act_flen - 7'd1);
  assign y_last  = (y_cnt == act_flen - 7'd1);
  assign g_last  = (g_cnt == act_g - 9'd1);
  assign last_in = x_last && y_last && g_last;
  assign emit    = s_hs && y_cnt[0] && x_cnt[0];

  // Configuration registers: FLEN and NUM_CH are plain RW storage; a frame
  // uses the copies latched at start, so writes mid-frame are harmless.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      flen_reg   <= '0;
      num_ch_reg <= '0;
    end else if (apb_wr) begin
      if (paddr_lo == 16'h0008) flen_reg   <= APB.PWDATA[6:0];
      if (paddr_lo == 16'h000C) num_ch_reg <= APB.PWDATA[8:0];
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: DRAIN waits for the final (TLAST) output to be taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (s_hs && last_in) state_d = DRAIN;
      DRAIN:   if (m_hs && m_last_q) state_d = DONE;
      DONE:    if (start_ok) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: accept input only in RUN and only when the output register
  // can take a new beat this cycle.
  always_comb begin
    s_tready = (state_q == RUN) && !(m_valid_q && !M_AXIS.TREADY);
    busy     = (state_q == RUN) || (state_q == DRAIN);
  end

  // Frame geometry latch and the g/x/y position counters.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      act_flen <= '0;
      act_g    <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      g_cnt    <= '0;
    end else if (start_ok) begin
      act_flen <= flen_reg;
      act_g    <= num_ch_reg / LANES_V;
      x_cnt    <= '0;
      y_cnt    <= '0;
      g_cnt    <= '0;
    end else if (s_hs) begin
      if (g_last) begin
        g_cnt <= '0;
        if (x_last) begin
          x_cnt <= '0;
          y_cnt <= y_last ? 7'd0 : y_cnt + 7'd1;
        end else begin
          x_cnt <= x_cnt + 7'd1;
        end
      end else begin
        g_cnt <= g_cnt + 9'd1;
      end
    end
  end

  // Sticky status flags, all cleared by an accepted start.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      tlast_err_q <= 1'b0;
    end else if (start_ok) begin
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      tlast_err_q <= 1'b0;
    end else begin
      if (start_bad) cfg_err_q <= 1'b1;
      if (s_hs && (S_AXIS.TLAST != last_in)) tlast_err_q <= 1'b1;
      if ((state_q == DRAIN) && m_hs && m_last_q) done_q <= 1'b1;
    end
  end

  // Busy-cycle counter; frozen once the frame finishes.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)       clk_count <= '0;
    else if (start_ok) clk_count <= '0;
    else if (busy)     clk_count <= clk_count + 32'd1;
  end

  // Line buffer address and window datapath; the read is asynchronous so
  // every accepted beat is handled in the cycle it arrives.
  always_comb begin
    idx_full  = 16'(x_cnt[6:1]) * 16'(act_g) + 16'(g_cnt);
    buf_idx   = idx_full[IDX_W-1:0];
    buf_rd    = line_buf[buf_idx];
    win_max   = lane_max(buf_rd, S_AXIS.TDATA);
    buf_we    = s_hs && !(y_cnt[0] && x_cnt[0]);
    buf_wdata = (!y_cnt[0] && !x_cnt[0]) ? S_AXIS.TDATA : win_max;
  end

  // Line buffer storage; contents need no reset.
  always_ff @(posedge CLK) begin
    if (buf_we) line_buf[buf_idx] <= buf_wdata;
  end

  // Output register: loaded by a window-completing beat, dropped on accept.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else if (emit) begin
      m_valid_q <= 1'b1;
      m_last_q  <= last_in;
      m_data_q  <= apply_relu(win_max);
    end else if (m_hs) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end
  end

  // APB read mux, combinational from the address.
  always_comb begin
    case (paddr_lo)
      16'h0004: APB.PRDATA = {27'd0, RELU_ON, busy, tlast_err_q, cfg_err_q, done_q};
      16'h0008: APB.PRDATA = {25'd0, flen_reg};
      16'h000C: APB.PRDATA = {23'd0, num_ch_reg};
      16'h0010: APB.PRDATA = clk_count;
      default:  APB.PRDATA = 32'd0;
    endcase
  end

  assign S_AXIS.TREADY = s_tready;
  assign M_AXIS.TVALID = m_valid_q;
  assign M_AXIS.TDATA  = m_data_q;
  assign M_AXIS.TLAST  = m_last_q;
  assign M_AXIS.TKEEP  = '1;
  assign M_AXIS.TUSER  = 1'b0;
  assign APB.PREADY    = 1'b1;
  assign APB.PSLVERR   = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXIS.TKEEP, S_AXIS.TUSER, APB.PADDR, APB.PWDATA, idx_full};

endmodule
